// File: rtl/fifo_lvl_if.sv
// Handshake/status bundle for fifo_lvl: the master side is the FIFO user,
// the slave side is the FIFO itself.
interface fifo_lvl_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
);
   logic              flush;
   logic              wr;
   logic [DWIDTH-1:0] w_data;
   logic              rd;
   logic [DWIDTH-1:0] r_data;
   logic              empty;
   logic              full;
   logic              almost_empty;
   logic              almost_full;
   logic [AWIDTH:0]   count;
   logic              err_clr;
   logic              overflow;
   logic              underflow;

   modport master (
      output flush, wr, w_data, rd, err_clr,
      input  r_data, empty, full, almost_empty, almost_full, count,
             overflow, underflow
   );

   modport slave (
      input  flush, wr, w_data, rd, err_clr,
      output r_data, empty, full, almost_empty, almost_full, count,
             overflow, underflow
   );
endinterface

// File: rtl/fifo_lvl.sv
// Synchronous show-ahead FIFO with occupancy count, almost-full/empty thresholds,
// flush and full-with-read writes. Define FIFO_ERR_EN for sticky overflow/underflow flags.
module fifo_lvl #(
   parameter int DWIDTH   = 8,
   parameter int AWIDTH   = 4,
   parameter int AE_LEVEL = 2,
   parameter int AF_LEVEL = 2**AWIDTH - 2
) (
   input  logic       clk,
   input  logic       reset,
   fifo_lvl_if.slave  bus
);

   localparam int              DEPTH   = 2**AWIDTH;
   localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_LEVEL);
   localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
   localparam logic [AWIDTH:0] ONE_C   = (AWIDTH+1)'(1);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [AWIDTH-1:0] w_ptr_q, w_ptr_d;
   logic [AWIDTH-1:0] r_ptr_q, r_ptr_d;
   logic [AWIDTH:0]   count_q, count_d;

   logic empty_s;
   logic full_s;
   logic r_en;
   logic w_en;
   logic mem_we;

   assign empty_s = (count_q == '0);
   assign full_s  = (count_q == DEPTH_C);

   // A write into a full FIFO is fine when the head leaves in the same cycle.
   assign r_en   = bus.rd & ~empty_s;
   assign w_en   = bus.wr & (~full_s | bus.rd);
   assign mem_we = w_en & ~reset & ~bus.flush;

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      if (bus.flush) begin
         w_ptr_d = '0;
         r_ptr_d = '0;
         count_d = '0;
      end else begin
         if (w_en)
            w_ptr_d = w_ptr_q + 1'b1;
         if (r_en)
            r_ptr_d = r_ptr_q + 1'b1;
         if (w_en && !r_en)
            count_d = count_q + ONE_C;
         else if (r_en && !w_en)
            count_d = count_q - ONE_C;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem_q[w_ptr_q] <= bus.w_data;
   end

   assign bus.r_data       = mem_q[r_ptr_q];
   assign bus.empty        = empty_s;
   assign bus.full         = full_s;
   assign bus.count        = count_q;
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.almost_full  = (count_q >= AF_C);

`ifdef FIFO_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;
   logic ovf_set;
   logic unf_set;

   assign ovf_set = bus.wr & full_s & ~bus.rd;
   assign unf_set = bus.rd & empty_s & ~bus.wr;

   // Setting beats clearing so an error in the err_clr cycle is not lost.
   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (bus.err_clr) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end
      if (ovf_set)
         ovf_d = 1'b1;
      if (unf_set)
         unf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.overflow   = 1'b0;
   assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// Directed self-checking bench for fifo_lvl with the default 8x16 geometry.
module tb_fifo_lvl;

`ifdef FIFO_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   fifo_lvl_if #(.DWIDTH(8), .AWIDTH(4)) bus ();

   fifo_lvl #(.DWIDTH(8), .AWIDTH(4), .AE_LEVEL(2), .AF_LEVEL(14)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush   = 1'b0;
      bus.wr      = 1'b0;
      bus.rd      = 1'b0;
      bus.w_data  = 8'h00;
      bus.err_clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         if (bus.count !== 5'd0) begin
            n_err++; $display("FAIL reset_count: got %0d want 0", bus.count);
         end
         n_vec++;
         if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full} !== 4'b1100) begin
            n_err++;
            $display("FAIL reset_flags: got e/ae/f/af=%b want 1100",
                     {bus.empty, bus.almost_empty, bus.full, bus.almost_full});
         end
         n_vec++;
         if ({bus.overflow, bus.underflow} !== 2'b00) begin
            n_err++; $display("FAIL reset_err: got ovf/unf=%b want 00", {bus.overflow, bus.underflow});
         end
         step();
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         bus.wr = 1'b1;
         bus.w_data = 8'(i);
         step();
         n_vec++;
         if (bus.count !== 5'(i + 1)) begin
            n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1);
         end
         n_vec++;
         if ({bus.empty, bus.almost_empty, bus.almost_full, bus.full} !==
             {1'b0, (i + 1 <= 2), (i + 1 >= 14), (i + 1 == 16)}) begin
            n_err++;
            $display("FAIL fill_flags[%0d]: got e/ae/af/f=%b want %b", i,
                     {bus.empty, bus.almost_empty, bus.almost_full, bus.full},
                     {1'b0, (i + 1 <= 2), (i + 1 >= 14), (i + 1 == 16)});
         end
         n_vec++;
         if (bus.r_data !== 8'h00) begin
            n_err++; $display("FAIL fill_head[%0d]: got %h want 00", i, bus.r_data);
         end
      end
      bus.w_data = 8'hEE;
      step();
      bus.wr = 1'b0;
      n_vec++;
      if (bus.count !== 5'd16 || bus.r_data !== 8'h00) begin
         n_err++; $display("FAIL drop_write: got count=%0d head=%h want 16/00", bus.count, bus.r_data);
      end
      n_vec++;
      if (bus.overflow !== ERR_EN) begin
         n_err++; $display("FAIL overflow_set: got %b want %b", bus.overflow, ERR_EN);
      end
      bus.err_clr = 1'b1;
      step();
      bus.err_clr = 1'b0;
      n_vec++;
      if (bus.overflow !== 1'b0) begin
         n_err++; $display("FAIL overflow_clr: got %b want 0", bus.overflow);
      end
   endtask

   task automatic test_back_to_back();
      bus.wr = 1'b1;
      bus.rd = 1'b1;
      bus.w_data = 8'hAA;
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (bus.r_data !== 8'(i)) begin
            n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bus.r_data, 8'(i));
         end
         step();
         n_vec++;
         if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
            n_err++; $display("FAIL b2b_count[%0d]: got %0d full=%b want 16/1", i, bus.count, bus.full);
         end
      end
      bus.wr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (bus.r_data !== 8'hAA) begin
            n_err++; $display("FAIL drain_data[%0d]: got %h want aa", i, bus.r_data);
         end
         step();
      end
      bus.rd = 1'b0;
      n_vec++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
         n_err++; $display("FAIL drain_end: got count=%0d empty=%b want 0/1", bus.count, bus.empty);
      end
   endtask

   task automatic test_underflow();
      bus.rd = 1'b1;
      step();
      n_vec++;
      if (bus.underflow !== ERR_EN || bus.count !== 5'd0) begin
         n_err++; $display("FAIL underflow_set: got unf=%b count=%0d want %b/0", bus.underflow, bus.count, ERR_EN);
      end
      bus.wr = 1'b1;
      bus.w_data = 8'h55;
      step();
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      n_vec++;
      if (bus.count !== 5'd1 || bus.r_data !== 8'h55) begin
         n_err++; $display("FAIL empty_rw: got count=%0d data=%h want 1/55", bus.count, bus.r_data);
      end
      n_vec++;
      if (bus.underflow !== ERR_EN) begin
         n_err++; $display("FAIL underflow_hold: got %b want %b", bus.underflow, ERR_EN);
      end
      bus.rd = 1'b1;
      step();
      bus.err_clr = 1'b1;
      step();
      bus.rd = 1'b0;
      bus.err_clr = 1'b0;
      n_vec++;
      if (bus.underflow !== ERR_EN || bus.count !== 5'd0) begin
         n_err++; $display("FAIL set_beats_clr: got unf=%b count=%0d want %b/0", bus.underflow, bus.count, ERR_EN);
      end
   endtask

   task automatic test_flush();
      bus.wr = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.w_data = 8'(8'h10 + i);
         step();
      end
      bus.wr = 1'b0;
      bus.rd = 1'b1;
      for (int i = 0; i < 12; i++) begin
         n_vec++;
         if (bus.r_data !== 8'(8'h10 + i)) begin
            n_err++; $display("FAIL wrap_read[%0d]: got %h want %h", i, bus.r_data, 8'(8'h10 + i));
         end
         step();
      end
      bus.rd = 1'b0;
      bus.wr = 1'b1;
      for (int i = 0; i < 9; i++) begin
         bus.w_data = 8'(8'h40 + i);
         step();
      end
      n_vec++;
      if (bus.count !== 5'd9 || bus.r_data !== 8'h40) begin
         n_err++; $display("FAIL wrap_fill: got count=%0d head=%h want 9/40", bus.count, bus.r_data);
      end
      bus.flush = 1'b1;
      bus.w_data = 8'h99;
      bus.rd = 1'b1;
      step();
      bus.flush = 1'b0;
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      n_vec++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
         n_err++; $display("FAIL flush: got count=%0d empty=%b want 0/1", bus.count, bus.empty);
      end
      n_vec++;
      if (bus.underflow !== ERR_EN) begin
         n_err++; $display("FAIL flush_keeps_err: got %b want %b", bus.underflow, ERR_EN);
      end
      bus.wr = 1'b1;
      bus.w_data = 8'h33;
      step();
      bus.wr = 1'b0;
      n_vec++;
      if (bus.count !== 5'd1 || bus.r_data !== 8'h33) begin
         n_err++; $display("FAIL post_flush: got count=%0d data=%h want 1/33", bus.count, bus.r_data);
      end
   endtask

   task automatic test_reset_mid();
      bus.wr = 1'b1;
      bus.w_data = 8'h60;
      step();
      bus.w_data = 8'h61;
      step();
      reset = 1'b1;
      bus.w_data = 8'h77;
      step();
      reset = 1'b0;
      bus.wr = 1'b0;
      n_vec++;
      if (bus.count !== 5'd0) begin
         n_err++; $display("FAIL midreset_count: got %0d want 0", bus.count);
      end
      n_vec++;
      if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.overflow, bus.underflow} !== 6'b110000) begin
         n_err++;
         $display("FAIL midreset_flags: got %b want 110000",
                  {bus.empty, bus.almost_empty, bus.full, bus.almost_full, bus.overflow, bus.underflow});
      end
      bus.wr = 1'b1;
      bus.w_data = 8'h88;
      step();
      bus.wr = 1'b0;
      n_vec++;
      if (bus.count !== 5'd1 || bus.r_data !== 8'h88) begin
         n_err++; $display("FAIL midreset_after: got count=%0d data=%h want 1/88", bus.count, bus.r_data);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_fill();
      test_back_to_back();
      test_underflow();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fifo_lvl.md
# fifo_lvl

Parametrised synchronous FIFO, successor to the UART buffer FIFO, for the UART TX/RX paths and the AHB-side data buffers. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and full-with-read write acceptance. Sticky overflow/underflow error flags are optional, for the status register. Storage is 2**AWIDTH words with show-ahead (combinational) read data.

## Interface
- DWIDTH, 8, data word width (>=1)
- AWIDTH, 4, address width; depth = 2**AWIDTH (>=1)
- AE_LEVEL, 2, almost_empty threshold (0..2**AWIDTH)
- AF_LEVEL, 2**AWIDTH-2, almost_full threshold (0..2**AWIDTH)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous discard of all contents
- wr  in  1  write request
- w_data  in  DWIDTH  write data
- rd  in  1  read request (pops the current head)
- r_data  out  DWIDTH  head word; valid while empty=0
- empty  out  1  count==0
- full  out  1  count==2**AWIDTH
- almost_empty  out  1  count<=AE_LEVEL
- almost_full  out  1  count>=AF_LEVEL
- count  out  AWIDTH+1  current occupancy
- err_clr  in  1  clear sticky error flags (FIFO_ERR_EN only)
- overflow  out  1  sticky: a write was dropped (FIFO_ERR_EN only)
- underflow  out  1  sticky: a read hit empty (FIFO_ERR_EN only)

## Operation
- State registers: w_ptr and r_ptr (AWIDTH bits, natural wrap at 2**AWIDTH), count (AWIDTH+1 bits), and the error flags.
- Read enable: r_en = rd & ~empty.
- Write enable: w_en = wr & (~full | rd). Writing while full is accepted when a read occurs in the same cycle.
- On w_en: mem[w_ptr] <= w_data; w_ptr += 1.
- On r_en: r_ptr += 1.
- count next value:
  - +1 on w_en & ~r_en
  - -1 on r_en & ~w_en
  - unchanged otherwise
- Empty and rd & wr together: the write is accepted. The read is ignored and does not raise underflow.
- Full and rd & wr together: both are accepted. count stays at 2**AWIDTH and both pointers advance.
- r_data = mem[r_ptr], read combinationally. Its value is undefined while empty.
- empty, full, almost_empty and almost_full decode combinationally from the registered count. They are glitch-free with respect to inputs.
- Precedence: reset > flush > normal operation.
- reset or flush: w_ptr=0, r_ptr=0, count=0, and wr/rd in that cycle are ignored. Memory contents are not cleared.
- Reset mid-operation discards all data. Outputs take their reset values at the next edge.

## Timing
- Reset values: count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), overflow=0, underflow=0. r_data is don't-care.
- Write latency: data written at edge N is visible on r_data after edge N when the FIFO was empty. empty falls after the same edge.
- Read: after the edge with r_en, r_data shows the next word. There are no wait states.
- Flags and count update after the same edge as the transfer that changes them.
- Sustained throughput: one write and one read per cycle at any occupancy, including full. At empty, a write and a read cannot both complete in the same cycle.

## Configuration
- Macro FIFO_ERR_EN.
- Defined:
  - overflow sets on wr & full & ~rd.
  - underflow sets on rd & empty & ~wr.
  - Both are sticky and clear on err_clr. A set condition in the same cycle as err_clr wins.
  - reset clears both; flush does not.
- Undefined:
  - err_clr, overflow and underflow are still present on the port list.
  - overflow and underflow are tied to 0 and err_clr is ignored.
  - No error registers are synthesised.

## Test plan
- Reset, then idle → count=0, empty=1, almost_empty=1, full=0, almost_full=0 (defaults DWIDTH=8, AWIDTH=4).
- Write 16 words 0x00..0x0F back-to-back → almost_full rises when count=14; full=1 at count=16. A 17th wr with rd=0 is dropped and sets overflow. err_clr then clears overflow.
- From full, wr and rd together with w_data=0xAA for 16 cycles → count stays 16. Reads return 0x00..0x0F in order; the next head is 0xAA.
- Empty, rd=1 alone → underflow=1, count=0. Then rd=wr=1 with 0x55 → count=1, r_data=0x55, underflow unchanged.
- Fill to 9 words across a pointer wrap (write 12, read 12, write 9), then flush → count=0 and empty=1 next cycle. Error flags hold. Write 0x33 → r_data=0x33.
- Assert reset mid-burst with wr=1 on the same edge → no write occurs and all outputs return to their reset values.
